// File: rtl/bus_drv_port_fifo_if.sv
// Port bundle between one device, its per-port FIFO pair and one arbiter port.
// The slave modport is the FIFO; the master modport is whoever drives the device and bus sides.
interface bus_drv_port_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    localparam int CW = $clog2(depth) + 1;

    logic               dev_push;
    logic [pckg_sz-1:0] dev_data_in;
    logic               dev_full;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               dev_pndng;
    logic [pckg_sz-1:0] dev_data_out;
    logic               dev_pop;
    logic [CW-1:0]      tx_count;
    logic [CW-1:0]      rx_count;
    logic               tx_ovf;
    logic               rx_ovf;

    modport slave (
        input  dev_push, dev_data_in, pop, push, D_push, dev_pop,
        output dev_full, pndng, D_pop, dev_pndng, dev_data_out,
               tx_count, rx_count, tx_ovf, rx_ovf
    );

    modport master (
        output dev_push, dev_data_in, pop, push, D_push, dev_pop,
        input  dev_full, pndng, D_pop, dev_pndng, dev_data_out,
               tx_count, rx_count, tx_ovf, rx_ovf
    );
endinterface

// File: rtl/bus_drv_port_fifo.sv
// Per-port dual first-word-fall-through FIFO: TX (device -> bus) and RX (bus -> device).
// Both queues share one circular-buffer implementation, instantiated twice below.
module bus_drv_port_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_drv_port_fifo_if.slave    bus
);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    // Index 0 is the TX queue, index 1 the RX queue.
    logic               w_wr_en   [2];
    logic [pckg_sz-1:0] w_wr_data [2];
    logic               w_rd_en   [2];
    logic [pckg_sz-1:0] w_head    [2];
    logic [CW-1:0]      w_count   [2];
    logic               w_ovf     [2];

    assign w_wr_en[0]   = bus.dev_push;
    assign w_wr_data[0] = bus.dev_data_in;
    assign w_rd_en[0]   = bus.pop;
    assign w_wr_en[1]   = bus.push;
    assign w_wr_data[1] = bus.D_push;
    assign w_rd_en[1]   = bus.dev_pop;

    for (genvar q = 0; q < 2; q++) begin : g_q
        logic [pckg_sz-1:0] r_mem [depth];
        logic [PW-1:0]      r_wr_ptr;
        logic [PW-1:0]      r_rd_ptr;
        logic [CW-1:0]      r_count;
        logic               r_ovf;
        logic               w_full;
        logic               w_empty;
        logic               w_do_rd;
        logic               w_do_wr;

        assign w_full  = (r_count == CW'(depth));
        assign w_empty = (r_count == '0);
        assign w_do_rd = w_rd_en[q] && !w_empty;
        // A pop frees the slot in the same cycle, so a write into a full queue still lands.
        assign w_do_wr = w_wr_en[q] && (!w_full || w_do_rd);

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
                else if (!w_do_wr && w_do_rd) r_count <= r_count - 1'b1;
                if (w_wr_en[q] && !w_do_wr) r_ovf <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset && w_do_wr) r_mem[r_wr_ptr] <= w_wr_data[q];
        end

        assign w_head[q]  = w_empty ? '0 : r_mem[r_rd_ptr];
        assign w_count[q] = r_count;
        assign w_ovf[q]   = r_ovf;
    end

    assign bus.pndng        = (w_count[0] != '0);
    assign bus.dev_full     = (w_count[0] == CW'(depth));
    assign bus.D_pop        = w_head[0];
    assign bus.tx_count     = w_count[0];
    assign bus.tx_ovf       = w_ovf[0];
    assign bus.dev_pndng    = (w_count[1] != '0);
    assign bus.dev_data_out = w_head[1];
    assign bus.rx_count     = w_count[1];
    assign bus.rx_ovf       = w_ovf[1];
endmodule

// File: tb/tb_bus_drv_port_fifo.sv
// Bench for bus_drv_port_fifo: directed plan steps followed by random traffic,
// each cycle compared against a queue-based reference model.
module tb_bus_drv_port_fifo;
    localparam int PSZ   = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_drv_port_fifo_if #(.pckg_sz(PSZ), .depth(DEPTH)) bif ();
    bus_drv_port_fifo #(.pckg_sz(PSZ), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    logic [PSZ-1:0] mtx[$];
    logic [PSZ-1:0] mrx[$];
    bit             mtx_ovf;
    bit             mrx_ovf;
    int             n_chk  = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit dp, input logic [PSZ-1:0] din, input bit pp,
                         input bit ps, input logic [PSZ-1:0] dps, input bit dpp);
        bif.dev_push    = dp;
        bif.dev_data_in = din;
        bif.pop         = pp;
        bif.push        = ps;
        bif.D_push      = dps;
        bif.dev_pop     = dpp;
    endtask

    // Reference behaviour in terms of queue occupancy only.
    task automatic model_update();
        bit pop_ok;
        bit wr_ok;
        if (!reset) begin
            mtx.delete();
            mrx.delete();
            mtx_ovf = 1'b0;
            mrx_ovf = 1'b0;
        end else begin
            pop_ok = bif.pop && (mtx.size() > 0);
            wr_ok  = bif.dev_push && ((mtx.size() < DEPTH) || pop_ok);
            if (bif.dev_push && !wr_ok) mtx_ovf = 1'b1;
            if (pop_ok) void'(mtx.pop_front());
            if (wr_ok) mtx.push_back(bif.dev_data_in);
            pop_ok = bif.dev_pop && (mrx.size() > 0);
            wr_ok  = bif.push && ((mrx.size() < DEPTH) || pop_ok);
            if (bif.push && !wr_ok) mrx_ovf = 1'b1;
            if (pop_ok) void'(mrx.pop_front());
            if (wr_ok) mrx.push_back(bif.D_push);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pndng"},        32'(bif.pndng),        32'(mtx.size() != 0));
        chk({tag, ".dev_full"},     32'(bif.dev_full),     32'(mtx.size() == DEPTH));
        chk({tag, ".D_pop"},        32'(bif.D_pop),        (mtx.size() != 0) ? 32'(mtx[0]) : 32'h0);
        chk({tag, ".tx_count"},     32'(bif.tx_count),     32'(mtx.size()));
        chk({tag, ".tx_ovf"},       32'(bif.tx_ovf),       32'(mtx_ovf));
        chk({tag, ".dev_pndng"},    32'(bif.dev_pndng),    32'(mrx.size() != 0));
        chk({tag, ".dev_data_out"}, 32'(bif.dev_data_out), (mrx.size() != 0) ? 32'(mrx[0]) : 32'h0);
        chk({tag, ".rx_count"},     32'(bif.rx_count),     32'(mrx.size()));
        chk({tag, ".rx_ovf"},       32'(bif.rx_ovf),       32'(mrx_ovf));
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int wr_pct;
        int rd_pct;
        reset = 1'b0;
        idle();
        step("rst0");
        step("rst1");
        reset = 1'b1;
        step("idle");
        chk("idle.tx_count_k", 32'(bif.tx_count), 32'h0);
        chk("idle.D_pop_k", 32'(bif.D_pop), 32'h0);

        // TX FIFO order
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, PSZ'(16'h0101 * i), 1'b0, 1'b0, '0, 1'b0);
            step("txord.wr");
            chk("txord.cnt_k", 32'(bif.tx_count), 32'(i));
        end
        for (int i = 1; i <= 3; i++) begin
            chk("txord.head_k", 32'(bif.D_pop), 32'(16'h0101 * i));
            drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            step("txord.pop");
        end
        chk("txord.pndng_k", 32'(bif.pndng), 32'h0);

        // TX full and overflow
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, PSZ'(16'h1000 + i), 1'b0, 1'b0, '0, 1'b0);
            step("ovf.wr");
            if (i == 7) chk("ovf.full_k", 32'(bif.dev_full), 32'h1);
        end
        chk("ovf.flag_k", 32'(bif.tx_ovf), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf.head_k", 32'(bif.D_pop), 32'(16'h1000 + i));
            drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            step("ovf.pop");
        end
        chk("ovf.sticky_k", 32'(bif.tx_ovf), 32'h1);
        idle();
        reset = 1'b0;
        step("ovf.rst");
        reset = 1'b1;

        // Write plus pop while full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, PSZ'(16'h2000 + i), 1'b0, 1'b0, '0, 1'b0);
            step("bfull.wr");
        end
        drive(1'b1, 16'h2FFF, 1'b1, 1'b0, '0, 1'b0);
        step("bfull.both");
        chk("bfull.cnt_k", 32'(bif.tx_count), 32'h8);
        chk("bfull.head_k", 32'(bif.D_pop), 32'h2001);
        chk("bfull.ovf_k", 32'(bif.tx_ovf), 32'h0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            step("bfull.drain");
        end

        // Write plus pop while RX empty
        drive(1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        step("bempty.both");
        chk("bempty.cnt_k", 32'(bif.rx_count), 32'h1);
        chk("bempty.data_k", 32'(bif.dev_data_out), 32'hBEEF);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step("bempty.drain");

        // RX path
        drive(1'b0, '0, 1'b0, 1'b1, 16'hA5A5, 1'b0);
        step("rx.wr0");
        drive(1'b0, '0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
        step("rx.wr1");
        chk("rx.pndng_k", 32'(bif.dev_pndng), 32'h1);
        chk("rx.head0_k", 32'(bif.dev_data_out), 32'hA5A5);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step("rx.pop0");
        chk("rx.head1_k", 32'(bif.dev_data_out), 32'h5A5A);
        step("rx.pop1");

        // Reset mid-operation with all strobes active
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, PSZ'(16'h3000 + i), 1'b0, (i < 3), PSZ'(16'h4000 + i), 1'b0);
            step("mid.fill");
        end
        drive(1'b1, 16'h3333, 1'b1, 1'b1, 16'h4444, 1'b1);
        reset = 1'b0;
        step("mid.rst");
        reset = 1'b1;
        idle();
        step("mid.after");
        chk("mid.tx_k", 32'(bif.tx_count), 32'h0);
        chk("mid.rx_k", 32'(bif.rx_count), 32'h0);
        chk("mid.dpop_k", 32'(bif.D_pop), 32'h0);

        // Random traffic with alternating write-heavy / read-heavy phases
        for (int c = 0; c < 800; c++) begin
            wr_pct = ((c / 100) % 2 == 0) ? 75 : 30;
            rd_pct = 100 - wr_pct;
            drive($urandom_range(99) < wr_pct, PSZ'($urandom),
                  $urandom_range(99) < rd_pct,
                  $urandom_range(99) < wr_pct, PSZ'($urandom),
                  $urandom_range(99) < rd_pct);
            reset = ($urandom_range(299) != 0);
            step("rand");
        end
        reset = 1'b1;
        idle();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_drv_port_fifo.md
Name: bus_drv_port_fifo

Overview:
- Per-port dual FIFO between one device and one port of the bus generator/arbiter (bs_gnrtr_n_rbtr). One instance per port, replicated drvrs times.
- The TX queue takes device writes and presents them to the bus through pndng/D_pop/pop.
- The RX queue takes bus deliveries through push/D_push and presents them to the device through dev_pndng/dev_data_out/dev_pop.
- It replaces the behavioural FIFO model currently used by the bench with synthesizable RTL.

Parameters:
- pckg_sz, 16, packet width in bits (same meaning as on the bus generator).
- depth, 8, entries per queue; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- dev_push  input  1  device writes dev_data_in into TX queue
- dev_data_in  input  pckg_sz  TX write data
- dev_full  output  1  TX queue full
- pndng  output  1  TX queue non-empty (to bus)
- D_pop  output  pckg_sz  TX head entry (to bus)
- pop  input  1  bus consumes TX head
- push  input  1  bus delivers D_push into RX queue
- D_push  input  pckg_sz  RX write data (from bus)
- dev_pndng  output  1  RX queue non-empty
- dev_data_out  output  pckg_sz  RX head entry
- dev_pop  input  1  device consumes RX head
- tx_count  output  $clog2(depth)+1  TX occupancy
- rx_count  output  $clog2(depth)+1  RX occupancy
- tx_ovf  output  1  sticky: a TX write was dropped
- rx_ovf  output  1  sticky: a RX write was dropped

Behaviour:
- Reset:
  - All state updates on posedge clk.
  - reset==0 sampled at an edge clears pointers, counts, tx_ovf and rx_ovf.
  - All outputs read 0 after that edge: pndng=0, dev_pndng=0, dev_full=0, D_pop=0, dev_data_out=0.
  - Reset dominates every push/pop in the same cycle.
  - Reset mid-operation discards all queued entries.
- Queue structure: the two queues are identical and fully independent. Each is a circular buffer with rd_ptr, wr_ptr and count registers.
- Pointer wrap: pointers wrap from depth-1 to 0.
- count range: 0..depth.
- Status flags:
  - full = (count==depth).
  - dev_full, pndng and dev_pndng are derived combinationally from count.
- First-word-fall-through:
  - D_pop and dev_data_out show the head entry combinationally whenever the queue is non-empty, and 0 when it is empty.
  - Latency: data written at edge N is visible at the head after edge N (zero added cycles) if the queue was empty.
- Write (push side), while not full:
  - Stores the data at wr_ptr.
  - Advances wr_ptr.
  - Increments count.
- Read (pop side), while non-empty:
  - Advances rd_ptr.
  - Decrements count.
- Simultaneous events:
  - Write while full, no pop: data dropped, ovf flag set to 1 from the next edge until reset; state otherwise unchanged.
  - Write while full with pop in the same cycle: both occur; count stays depth; no overflow.
  - Pop while empty: ignored; no error flag.
  - Pop while empty with write in the same cycle: the write is accepted; count becomes 1. The pop is not applied to the new entry.
  - Write and pop while 0<count<depth: both occur; count unchanged.
- No data transformation: packets pass bit-exact in FIFO order.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release → pndng=0, dev_pndng=0, dev_full=0, counts=0, ovf=0, D_pop=0.
- TX FIFO order: write 0x0101, 0x0202, 0x0303 with dev_push, then pop three times → D_pop sequence 0x0101, 0x0202, 0x0303; pndng drops after the 3rd pop; tx_count goes 1, 2, 3, then back to 0.
- TX full/overflow:
  - 9 consecutive writes with depth=8 → dev_full=1 after the 8th write; 9th data dropped; tx_ovf=1.
  - 8 pops then return the first 8 values in order; tx_ovf stays 1 until reset.
- Simultaneous at boundaries:
  - At count=8: dev_push+pop in one cycle → count stays 8; head advances; tx_ovf=0.
  - At count=0: push+dev_pop on RX → rx_count=1; dev_data_out=D_push.
- RX path: bus push 0xA5A5 then 0x5A5A → dev_pndng=1 and dev_data_out=0xA5A5; after dev_pop, dev_data_out=0x5A5A.
- Reset mid-operation: TX holds 5 entries and RX holds 3; assert reset for 1 cycle with push and pop both active → both counts 0, flags 0, and the pushed data not stored.
